bus_memory_responder: RTL and testbench

//  Word-addressed RAM acting as the responder (slave) end of the core's bus master

---
 rtl/bus_memory_responder_pkg.sv | 34 +++
 rtl/bus_memory_responder_word_ram.sv | 29 ++
 rtl/bus_memory_responder.sv | 125 ++++++++++++
 tb/tb_bus_memory_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_memory_responder_pkg.sv
// Shared types for the bus memory responder: request/response records and
// the responder FSM state encoding.
package bus_memory_responder_pkg;

    // Request captured from the master at accept time.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_request_t;

    // Response held stable while the master has not yet consumed it.
    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } bus_response_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACCESS  = 2'd2,
        RESPOND = 2'd3
    } responder_state_t;

    // Width of the wait-state counter (wait states range 0..15).
    localparam int unsigned WAIT_CNT_W = 4;

    // Bus words are 32 bits; the two low byte-address bits must be zero.
    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/bus_memory_responder_word_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Storage is intentionally not reset.
module word_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes and read-before-write into the output register.
    always_ff @(posedge clock) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_memory_responder.sv
// Word-addressed RAM acting as a bus responder. One request in flight at a
// time, optional wait states, one response per request, decode errors for
// out-of-range or misaligned addresses.
//
// Handshakes: a transfer on either channel happens on a rising clock edge
// where valid and ready are both high. The request channel is only ready in
// IDLE; the response channel is only valid in RESPOND, where rdata/error stay
// stable until the transfer completes.
module bus_memory_responder
    import bus_memory_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned SIZE_WORDS  = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic             req_write,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_wstrb,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_error,
    output responder_state_t dbg_state
);

    localparam int unsigned AW = $clog2(SIZE_WORDS);
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(SIZE_WORDS) << 2);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES - 1);

    responder_state_t      state, next_state;
    bus_request_t          req_q;
    bus_response_t         resp_q;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    // ACCESS spans two cycles: issue the RAM operation, then register the
    // RAM output into the response.
    logic                  access_phase;

    logic                  accept;
    logic                  in_range;
    logic                  addr_ok;
    logic [31:0]           offset;
    logic [AW-1:0]         word_idx;
    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;

    assign accept   = req_valid & req_ready;
    assign offset   = req_q.addr - BASE_ADDR;
    assign word_idx = AW'(offset >> 2);
    assign in_range = ({1'b0, req_q.addr} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, req_q.addr} < END_ADDR);
    assign addr_ok  = in_range && word_aligned(req_q.addr);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (wait_cnt == WAIT_LAST) next_state = ACCESS;
            ACCESS:  if (access_phase) next_state = RESPOND;
            RESPOND: if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: handshake readiness and RAM strobes.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESPOND);
        ram_en     = (state == ACCESS) && !access_phase && addr_ok;
        ram_we     = (ram_en && req_q.write) ? req_q.wstrb : 4'b0000;
    end

    // Request latch, wait counter, access phase and response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_q        <= '0;
            resp_q       <= '0;
            wait_cnt     <= '0;
            access_phase <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= '{addr: req_addr, write: req_write,
                           wdata: req_wdata, wstrb: req_wstrb};
            end
            wait_cnt     <= (state == WAIT) ? wait_cnt + WAIT_CNT_W'(1) : '0;
            access_phase <= (state == ACCESS) && !access_phase;
            if (state == ACCESS && access_phase) begin
                resp_q.rdata <= (addr_ok && !req_q.write) ? ram_rdata : 32'h0;
                resp_q.error <= !addr_ok;
            end
        end
    end

    assign resp_rdata = resp_q.rdata;
    assign resp_error = resp_q.error;
    assign dbg_state  = state;

    word_ram #(
        .DEPTH (SIZE_WORDS),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (word_idx),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_bus_memory_responder.sv
// Bench for bus_memory_responder: directed transactions, a transaction-level
// memory model with an expected-response queue, and a per-cycle compare.
module tb_bus_memory_responder;
  import bus_memory_responder_pkg::*;

  localparam int          W    = 3;
  localparam int          SIZE = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_addr = '0;
  logic             req_write = 1'b0;
  logic [31:0]      req_wdata = '0;
  logic [3:0]       req_wstrb = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_rdata;
  logic             resp_error;
  responder_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  bus_memory_responder #(
    .BASE_ADDR   (BASE),
    .SIZE_WORDS  (SIZE),
    .WAIT_CYCLES (W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  logic [31:0] m_mem [SIZE];
  logic [32:0] exp_q [$];
  bit          pending;
  int          edges;
  int          due;
  int          ram_edge;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wr;
  logic        m_err;

  // Outputs are compared at each falling edge; the model then advances to
  // the upcoming rising edge using the handshakes visible now.
  always @(negedge clock) begin
    if (!reset) begin
      pending = 1'b0;
      edges   = 0;
      exp_q.delete();
    end else begin
      chk("req_ready", 32'(req_ready), 32'(!pending));
      chk("resp_valid", 32'(resp_valid), 32'(pending && edges >= due));
      if (resp_valid && exp_q.size() > 0) begin
        chk("resp_rdata", resp_rdata, exp_q[0][31:0]);
        chk("resp_error", 32'(resp_error), 32'(exp_q[0][32]));
      end
      // Store lands in memory on the RAM edge, one edge before the response.
      if (pending && edges + 1 == ram_edge && m_wr && !m_err) begin
        for (int i = 0; i < 4; i++) begin
          if (m_wstrb[i]) m_mem[m_addr[7:2]][8*i +: 8] = m_wdata[8*i +: 8];
        end
      end
      if (req_valid && req_ready) begin
        m_addr   = req_addr;
        m_wdata  = req_wdata;
        m_wstrb  = req_wstrb;
        m_wr     = req_write;
        m_err    = !((req_addr >= BASE) && (req_addr - BASE < 32'(4 * SIZE)) &&
                     (req_addr % 4 == 0));
        pending  = 1'b1;
        due      = edges + 1 + 2 + W;
        ram_edge = edges + 1 + 1 + W;
        exp_q.push_back({m_err, (m_err || m_wr) ? 32'h0 : m_mem[req_addr[7:2]]});
      end
      if (resp_valid && resp_ready) begin
        pending = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      edges++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] ws, input int stall,
                        output logic [31:0] rd, output logic err, output int lat);
    int n;
    @(posedge clock); #2;
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    req_wstrb = ws;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout addr %h", addr);
    end
    @(posedge clock); #2;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
    req_wstrb = 4'($urandom_range(0, 15));
    lat = 0;
    forever begin
      @(negedge clock);
      if (resp_valid || lat >= 50) break;
      @(posedge clock);
      lat++;
    end
    if (!resp_valid) begin
      errors++;
      $display("FAIL resp_timeout addr %h", addr);
    end
    rd  = resp_rdata;
    err = resp_error;
    @(posedge clock); #2;
    repeat (stall) begin
      @(posedge clock); #2;
    end
    resp_ready = 1'b1;
    @(posedge clock); #2;
    resp_ready = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        err;
    int          lat;

    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    do_req(32'h10, 1'b1, 32'hDEAD_BEEF, 4'b1111, 0, rd, err, lat);
    chk("st_full_err", 32'(err), 32'd0);
    chk("st_full_rdata", rd, 32'h0);
    chk("st_latency", 32'(lat), 32'(2 + W));
    do_req(32'h10, 1'b0, 32'h0, 4'b0000, 0, rd, err, lat);
    chk("ld_full", rd, 32'hDEAD_BEEF);
    chk("ld_full_err", 32'(err), 32'd0);
    chk("ld_latency", 32'(lat), 32'd5);

    do_req(32'h10, 1'b1, 32'h0000_00AA, 4'b0001, 0, rd, err, lat);
    do_req(32'h10, 1'b0, 32'h0, 4'b0000, 0, rd, err, lat);
    chk("ld_byte0", rd, 32'hDEAD_BEAA);

    do_req(32'h12, 1'b0, 32'h0, 4'b0000, 0, rd, err, lat);
    chk("misal_err", 32'(err), 32'd1);
    chk("misal_rdata", rd, 32'h0);
    do_req(32'(4 * SIZE), 1'b0, 32'h0, 4'b0000, 0, rd, err, lat);
    chk("oor_err", 32'(err), 32'd1);
    chk("oor_rdata", rd, 32'h0);
    do_req(32'hFFFF_FFFC, 1'b0, 32'h0, 4'b0000, 0, rd, err, lat);
    chk("top_err", 32'(err), 32'd1);

    do_req(32'h10, 1'b1, 32'hFFFF_FFFF, 4'b0000, 0, rd, err, lat);
    chk("nostrb_err", 32'(err), 32'd0);
    do_req(32'h11, 1'b1, 32'h1234_5678, 4'b1111, 0, rd, err, lat);
    chk("st_misal_err", 32'(err), 32'd1);
    do_req(32'(4 * SIZE), 1'b1, 32'h1234_5678, 4'b1111, 0, rd, err, lat);
    chk("st_oor_err", 32'(err), 32'd1);
    do_req(32'h10, 1'b0, 32'h0, 4'b0000, 0, rd, err, lat);
    chk("ld_unchanged", rd, 32'hDEAD_BEAA);

    do_req(32'(4 * SIZE - 4), 1'b1, 32'hCAFE_F00D, 4'b1111, 0, rd, err, lat);
    chk("st_last_err", 32'(err), 32'd0);
    do_req(32'(4 * SIZE - 4), 1'b1, 32'h0A0B_0C0D, 4'b1010, 0, rd, err, lat);
    do_req(32'(4 * SIZE - 4), 1'b0, 32'h0, 4'b0000, 0, rd, err, lat);
    chk("ld_last_lanes", rd, 32'h0AFE_0C0D);

    // Response stall: master keeps resp_ready low for several cycles.
    fork
      do_req(32'h10, 1'b0, 32'h0, 4'b0000, 4, rd, err, lat);
      begin
        repeat (12) @(posedge clock);
        #1 chk("stall_state", 32'(dbg_state), 32'(RESPOND));
      end
    join
    chk("stall_latency", 32'(lat), 32'd5);
    chk("stall_rdata", rd, 32'hDEAD_BEAA);

    // Reset while a store is still waiting: it must never commit.
    do_req(32'h20, 1'b1, 32'h1122_3344, 4'b1111, 0, rd, err, lat);
    @(posedge clock); #2;
    req_valid = 1'b1;
    req_addr  = 32'h20;
    req_write = 1'b1;
    req_wdata = 32'h5566_7788;
    req_wstrb = 4'b1111;
    @(negedge clock);
    chk("rw_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #2;
    req_valid = 1'b0;
    @(posedge clock); #1;
    chk("rw_in_wait", 32'(dbg_state), 32'(WAIT));
    #1 reset = 1'b0;
    #1;
    chk("rw_rst_ready", 32'(req_ready), 32'd1);
    chk("rw_rst_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    repeat (8) begin
      @(negedge clock);
      chk("rw_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req(32'h20, 1'b0, 32'h0, 4'b0000, 0, rd, err, lat);
    chk("rw_old_data", rd, 32'h1122_3344);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
